uart_link_fifo: RTL
===================

Name: uart_link_fifo

Overview:
- Parametrised full-duplex UART link, successor to the fixed 8-bit UART core used under the protocol layer.
- Adds a configurable data width, oversampling factor, stop-bit count, a TX FIFO, a mid-bit RX sampler with false-start rejection, and framing and overrun detection.
- Sits between the pin pair (io_pair_rx/io_pair_tx) and the command/protocol engine, with the same ready/valid byte interface.

Parameters:
- DATA_W, 8: data bits per frame (5..9), sent LSB first.
- OVS, 16: clock cycles per bit period (even, >=4).
- TX_DEPTH, 4: TX FIFO entries (power of 2, >=2).
- STOP_BITS, 1: stop bits transmitted (1 or 2). RX always checks exactly one.

Ports:
- clock  in  1  system clock. One clock domain only.
- reset  in  1  synchronous, active-high reset.
- io_pair_rx  in  1  serial input, asynchronous to clock, idle high.
- io_pair_tx  out  1  serial output, idle high.
- io_dataIn_bits  in  DATA_W  byte to transmit.
- io_dataIn_valid  in  1  producer has a byte.
- io_dataIn_ready  out  1  FIFO can accept a byte; high when count < TX_DEPTH.
- io_dataOut_bits  out  DATA_W  received byte.
- io_dataOut_valid  out  1  received byte available.
- io_dataOut_ready  in  1  consumer takes the byte.
- tx_count  out  $clog2(TX_DEPTH)+1  current FIFO occupancy.
- tx_busy  out  1  TX FSM not in IDLE.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: received byte overwrote an unconsumed byte.
- parity_err  out  1  one-cycle pulse on a parity mismatch; see Optional Feature.

Behaviour:
- Reset values:
  - io_pair_tx=1, io_dataIn_ready=1, io_dataOut_valid=0, io_dataOut_bits=0.
  - tx_count=0, tx_busy=0, all error pulses 0.
  - FIFO emptied; both FSMs in IDLE; bit counters 0.
- Reset mid-frame aborts the frame. io_pair_tx is 1 the cycle after reset is sampled.
- All outputs are registered.

TX FIFO:
- Push when io_dataIn_valid & io_dataIn_ready at a clock edge.
- Pop when the TX FSM is in IDLE and count>0.
- Push and pop in the same cycle leave the count unchanged.
- Push while full is impossible because ready=0. Pointers wrap modulo TX_DEPTH.

TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- Each state holds the line for OVS cycles per bit.
- DATA lasts DATA_W bits. STOP lasts STOP_BITS bits.
- The edge that pops enters START, so io_pair_tx=0 from that edge on.
- A byte pushed into an empty idle FIFO at edge N drives the start bit after edge N+1.
- Back-to-back frames: if the FIFO is non-empty at the end of STOP, the next START follows immediately with no idle bit.

RX path:
- 2-flop synchroniser on io_pair_rx; all RX logic uses the synchronised value.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: a synchronised low enters START with the counter loaded to OVS/2-1.
- START: at the mid-bit point, a high line is a false start and returns to IDLE with no output.
- DATA: sampled every OVS cycles at mid-bit, shifting in LSB first.
- STOP sample high: load io_dataOut_bits and set io_dataOut_valid on the next edge.
- STOP sample low: pulse frame_err, discard the byte, return to IDLE, and wait for the line to go high before re-arming.
- io_dataOut_valid stays high until io_dataOut_ready is sampled high, then clears.
- A new byte completing while valid is still high overwrites the data, keeps valid=1 and pulses overrun.
- A new byte completing in the same cycle the consumer takes the old one: the new byte is loaded and valid stays 1, with no overrun.

Optional Feature:
- Macro: UART_LINK_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of the data bits) is sent after DATA. Frame length becomes 1+DATA_W+1+STOP_BITS bits.
  - RX samples the parity bit. A mismatch pulses parity_err and discards the byte; the stop-bit check still runs.
- Undefined: no PARITY state in either FSM; parity_err is tied to 0. The port list is the same in both builds.

Test Plan (defaults, parity off unless stated):
- Push 0x54 into an idle link -> io_pair_tx low 16 cycles, then bits 0,0,1,0,1,0,1,0 for 16 cycles each, then high 16 cycles. 160 cycles total; tx_busy high throughout.
- Push 6 bytes on consecutive cycles -> 5 accepted (one pops at once); io_dataIn_ready low after the 5th with tx_count=4. The 6th is accepted after the first frame ends; all 6 frames transmit with no idle gaps.
- Drive 0xA5 on rx at 16 cycles/bit, io_dataOut_ready=0 -> io_dataOut_valid rises ~2 sync + 9.5 bit times after the falling edge, bits=0xA5. A second frame 0x3C before ready -> overrun pulse, bits=0x3C.
- Drive 0x81 with stop bit 0 -> frame_err single pulse; io_dataOut_valid stays 0. A glitch low for 4 cycles -> no reception and no errors.
- Reset asserted mid-data-bit of a TX frame with 3 bytes queued -> next cycle io_pair_tx=1, tx_count=0, tx_busy=0, io_dataIn_ready=1.
- UART_LINK_PARITY_EN: push 0x07 -> parity bit 1 before stop. Receive 0x07 with parity 0 -> parity_err pulse, no valid.

Source files
------------

// File: rtl/uart_link_fifo.sv
// Full-duplex UART link: TX FIFO + TX framer, mid-bit RX sampler with false-start,
// framing and overrun detection. Optional even parity via `define UART_LINK_PARITY_EN.
module uart_link_fifo #(
    parameter int DATA_W    = 8,
    parameter int OVS       = 16,
    parameter int TX_DEPTH  = 4,
    parameter int STOP_BITS = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      io_pair_rx,
    output logic                      io_pair_tx,
    input  logic [DATA_W-1:0]         io_dataIn_bits,
    input  logic                      io_dataIn_valid,
    output logic                      io_dataIn_ready,
    output logic [DATA_W-1:0]         io_dataOut_bits,
    output logic                      io_dataOut_valid,
    input  logic                      io_dataOut_ready,
    output logic [$clog2(TX_DEPTH):0] tx_count,
    output logic                      tx_busy,
    output logic                      frame_err,
    output logic                      overrun,
    output logic                      parity_err
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int CNT_W = $clog2(OVS);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(OVS - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(OVS / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [3:0]       DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [CW-1:0]    DEPTH_C   = CW'(TX_DEPTH);
    localparam logic [CW-1:0]    CW_ONE    = CW'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

`ifdef UART_LINK_PARITY_EN
    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
`ifdef UART_LINK_PARITY_EN
        TX_PARITY = 3'd3,
`endif
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_LINK_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4,
        RX_WAIT   = 3'd5
    } rx_state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] fifo_mem_r [TX_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CW-1:0]     fifo_cnt_r, fifo_cnt_n_s;
    logic              in_ready_r;
    logic              push_s, pop_s;

    // TX FSM state
    tx_state_t         tx_state_r, tx_state_n_s;
    logic [CNT_W-1:0]  tx_cnt_r, tx_cnt_n_s;
    logic [3:0]        tx_bit_r, tx_bit_n_s;
    logic [DATA_W-1:0] tx_sh_r, tx_sh_n_s;
`ifdef UART_LINK_PARITY_EN
    logic              tx_par_r, tx_par_n_s;
`endif
    logic              tx_line_r, tx_line_n_s, tx_busy_r;

    assign push_s = io_dataIn_valid & in_ready_r;

    // Occupancy after this cycle's push/pop
    always_comb begin
        fifo_cnt_n_s = fifo_cnt_r;
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_n_s = fifo_cnt_r + CW_ONE;
            2'b01:   fifo_cnt_n_s = fifo_cnt_r - CW_ONE;
            default: fifo_cnt_n_s = fifo_cnt_r;
        endcase
    end

    // FIFO storage, pointers, occupancy and registered ready
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < TX_DEPTH; i++) fifo_mem_r[i] <= {DATA_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CW{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= io_dataIn_bits;
                wr_ptr_r             <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
            fifo_cnt_r <= fifo_cnt_n_s;
            in_ready_r <= (fifo_cnt_n_s < DEPTH_C);
        end
    end

    // A frame starts from IDLE or straight out of the final stop bit (no idle gap)
    always_comb begin
        if (fifo_cnt_r != {CW{1'b0}}) begin
            pop_s = (tx_state_r == TX_IDLE) ||
                    ((tx_state_r == TX_STOP) && (tx_cnt_r == CNT_ZERO) && (tx_bit_r == STOP_LAST));
        end else begin
            pop_s = 1'b0;
        end
    end

    // TX FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= 4'd0;
            tx_sh_r    <= {DATA_W{1'b0}};
`ifdef UART_LINK_PARITY_EN
            tx_par_r   <= 1'b0;
`endif
        end else begin
            tx_state_r <= tx_state_n_s;
            tx_cnt_r   <= tx_cnt_n_s;
            tx_bit_r   <= tx_bit_n_s;
            tx_sh_r    <= tx_sh_n_s;
`ifdef UART_LINK_PARITY_EN
            tx_par_r   <= tx_par_n_s;
`endif
        end
    end

    // TX FSM next-state logic
    always_comb begin
        tx_state_n_s = tx_state_r;
        tx_cnt_n_s   = tx_cnt_r;
        tx_bit_n_s   = tx_bit_r;
        tx_sh_n_s    = tx_sh_r;
`ifdef UART_LINK_PARITY_EN
        tx_par_n_s   = tx_par_r;
`endif
        if (pop_s) begin
            tx_state_n_s = TX_START;
            tx_cnt_n_s   = CNT_MAX;
            tx_bit_n_s   = 4'd0;
            tx_sh_n_s    = fifo_mem_r[rd_ptr_r];
`ifdef UART_LINK_PARITY_EN
            tx_par_n_s   = even_par(fifo_mem_r[rd_ptr_r]);
`endif
        end else if (tx_state_r != TX_IDLE && tx_cnt_r != CNT_ZERO) begin
            tx_cnt_n_s = tx_cnt_r - CNT_ONE;
        end else begin
            tx_cnt_n_s = CNT_MAX;
            case (tx_state_r)
                TX_IDLE: tx_cnt_n_s = CNT_ZERO;
                TX_START: begin
                    tx_state_n_s = TX_DATA;
                    tx_bit_n_s   = 4'd0;
                end
                TX_DATA: begin
                    tx_sh_n_s = {1'b0, tx_sh_r[DATA_W-1:1]};
                    if (tx_bit_r == DATA_LAST) begin
`ifdef UART_LINK_PARITY_EN
                        tx_state_n_s = TX_PARITY;
`else
                        tx_state_n_s = TX_STOP;
`endif
                        tx_bit_n_s = 4'd0;
                    end else begin
                        tx_bit_n_s = tx_bit_r + 4'd1;
                    end
                end
`ifdef UART_LINK_PARITY_EN
                TX_PARITY: begin
                    tx_state_n_s = TX_STOP;
                    tx_bit_n_s   = 4'd0;
                end
`endif
                TX_STOP: begin
                    if (tx_bit_r == STOP_LAST) begin
                        tx_state_n_s = TX_IDLE;
                        tx_bit_n_s   = 4'd0;
                    end else begin
                        tx_bit_n_s = tx_bit_r + 4'd1;
                    end
                end
                default: begin
                    tx_state_n_s = TX_IDLE;
                    tx_bit_n_s   = 4'd0;
                end
            endcase
        end
    end

    // TX line level for the state being entered, so the pin is registered without lag
    always_comb begin
        case (tx_state_n_s)
            TX_IDLE:   tx_line_n_s = 1'b1;
            TX_START:  tx_line_n_s = 1'b0;
            TX_DATA:   tx_line_n_s = tx_sh_n_s[0];
`ifdef UART_LINK_PARITY_EN
            TX_PARITY: tx_line_n_s = tx_par_n_s;
`endif
            TX_STOP:   tx_line_n_s = 1'b1;
            default:   tx_line_n_s = 1'b1;
        endcase
    end

    // Registered TX pin and busy flag
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_line_r <= 1'b1;
            tx_busy_r <= 1'b0;
        end else begin
            tx_line_r <= tx_line_n_s;
            tx_busy_r <= (tx_state_n_s != TX_IDLE);
        end
    end

    // ---------------- RX path ----------------
    logic              rx_meta_r, rx_sync_r;
    rx_state_t         rx_state_r, rx_state_n_s;
    logic [CNT_W-1:0]  rx_cnt_r, rx_cnt_n_s;
    logic [3:0]        rx_bit_r, rx_bit_n_s;
    logic [DATA_W-1:0] rx_sh_r, rx_sh_n_s;
`ifdef UART_LINK_PARITY_EN
    logic              rx_pbad_r, rx_pbad_n_s;
`endif
    logic              done_s, ferr_s, perr_s;
    logic [DATA_W-1:0] out_bits_r;
    logic              out_valid_r, ferr_r, ovr_r, perr_r;

    // Two-flop synchroniser for the asynchronous RX pin
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= io_pair_rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // RX FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_bit_r   <= 4'd0;
            rx_sh_r    <= {DATA_W{1'b0}};
`ifdef UART_LINK_PARITY_EN
            rx_pbad_r  <= 1'b0;
`endif
        end else begin
            rx_state_r <= rx_state_n_s;
            rx_cnt_r   <= rx_cnt_n_s;
            rx_bit_r   <= rx_bit_n_s;
            rx_sh_r    <= rx_sh_n_s;
`ifdef UART_LINK_PARITY_EN
            rx_pbad_r  <= rx_pbad_n_s;
`endif
        end
    end

    // RX FSM next-state logic; counter hitting zero marks the mid-bit sample point
    always_comb begin
        rx_state_n_s = rx_state_r;
        rx_cnt_n_s   = rx_cnt_r;
        rx_bit_n_s   = rx_bit_r;
        rx_sh_n_s    = rx_sh_r;
`ifdef UART_LINK_PARITY_EN
        rx_pbad_n_s  = rx_pbad_r;
`endif
        case (rx_state_r)
            RX_IDLE: begin
                if (!rx_sync_r) begin
                    rx_state_n_s = RX_START;
                    rx_cnt_n_s   = CNT_HALF;
                end else begin
                    rx_cnt_n_s = CNT_ZERO;
                end
            end
            RX_WAIT: begin
                if (rx_sync_r) rx_state_n_s = RX_IDLE;
                else           rx_state_n_s = RX_WAIT;
            end
            default: begin
                if (rx_cnt_r != CNT_ZERO) begin
                    rx_cnt_n_s = rx_cnt_r - CNT_ONE;
                end else begin
                    rx_cnt_n_s = CNT_MAX;
                    case (rx_state_r)
                        RX_START: begin
                            if (rx_sync_r) rx_state_n_s = RX_IDLE;
                            else           rx_state_n_s = RX_DATA;
                            rx_bit_n_s = 4'd0;
                        end
                        RX_DATA: begin
                            rx_sh_n_s = {rx_sync_r, rx_sh_r[DATA_W-1:1]};
                            if (rx_bit_r == DATA_LAST) begin
`ifdef UART_LINK_PARITY_EN
                                rx_state_n_s = RX_PARITY;
                                rx_pbad_n_s  = 1'b0;
`else
                                rx_state_n_s = RX_STOP;
`endif
                                rx_bit_n_s = 4'd0;
                            end else begin
                                rx_bit_n_s = rx_bit_r + 4'd1;
                            end
                        end
`ifdef UART_LINK_PARITY_EN
                        RX_PARITY: begin
                            rx_pbad_n_s  = perr_s;
                            rx_state_n_s = RX_STOP;
                        end
`endif
                        RX_STOP: begin
                            if (rx_sync_r) rx_state_n_s = RX_IDLE;
                            else           rx_state_n_s = RX_WAIT;
                        end
                        default: rx_state_n_s = RX_IDLE;
                    endcase
                end
            end
        endcase
    end

    // RX FSM outputs: byte completion and error strobes
    always_comb begin
        done_s = 1'b0;
        ferr_s = 1'b0;
        perr_s = 1'b0;
        if (rx_cnt_r == CNT_ZERO && rx_state_r == RX_STOP) begin
`ifdef UART_LINK_PARITY_EN
            done_s = rx_sync_r & ~rx_pbad_r;
`else
            done_s = rx_sync_r;
`endif
            ferr_s = ~rx_sync_r;
`ifdef UART_LINK_PARITY_EN
        end else if (rx_cnt_r == CNT_ZERO && rx_state_r == RX_PARITY) begin
            perr_s = (rx_sync_r != even_par(rx_sh_r));
`endif
        end else begin
            done_s = 1'b0;
        end
    end

    // Received-byte holding register, valid handshake and error pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            out_bits_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            ferr_r      <= 1'b0;
            ovr_r       <= 1'b0;
            perr_r      <= 1'b0;
        end else begin
            ferr_r <= ferr_s;
            perr_r <= perr_s;
            if (done_s) begin
                out_bits_r  <= rx_sh_r;
                out_valid_r <= 1'b1;
                ovr_r       <= out_valid_r & ~io_dataOut_ready;
            end else begin
                ovr_r <= 1'b0;
                if (out_valid_r && io_dataOut_ready) out_valid_r <= 1'b0;
                else                                 out_valid_r <= out_valid_r;
            end
        end
    end

    assign io_pair_tx       = tx_line_r;
    assign io_dataIn_ready  = in_ready_r;
    assign io_dataOut_bits  = out_bits_r;
    assign io_dataOut_valid = out_valid_r;
    assign tx_count         = fifo_cnt_r;
    assign tx_busy          = tx_busy_r;
    assign frame_err        = ferr_r;
    assign overrun          = ovr_r;
    assign parity_err       = perr_r;

endmodule
